stump_dma_arbiter: RTL

//  Block-copy DMA engine that shares the Stump's single memory port with the CPU.

---
 rtl/stump_dma_arbiter.sv | 86 ++++++++
 1 files changed

// File: rtl/stump_dma_arbiter.sv
// stump_dma_arbiter: block-copy DMA engine that shares the Stump memory port, yielding to the CPU.
// DMA words move only in cycles where the CPU makes no memory access, so the CPU never stalls.
module stump_dma_arbiter #(
  parameter int          LEN_W   = 8,
  parameter logic [15:0] PTR_INC = 16'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      cpu_address,
  input  logic [15:0]      cpu_data_out,
  input  logic             cpu_ren,
  input  logic             cpu_wen,
  output logic [15:0]      mem_address,
  output logic [15:0]      mem_wdata,
  output logic             mem_ren,
  output logic             mem_wen,
  input  logic [15:0]      mem_rdata,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [15:0]      cmd_src,
  input  logic [15:0]      cmd_dst,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             abort,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] src_q, src_d, dst_q, dst_d, buf_q, buf_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic cpu_act, dma_rd, dma_wr;
  assign cpu_act = cpu_ren | cpu_wen;
  assign dma_rd = !cpu_act && state_q == READ;
  assign dma_wr = !cpu_act && state_q == WRITE;
  // DMA strobes are gated by !cpu_act, so CPU values reach memory untouched
  assign mem_ren = cpu_ren | dma_rd;
  assign mem_wen = cpu_wen | dma_wr;
  assign mem_address = dma_rd ? src_q : dma_wr ? dst_q : cpu_address;
  assign mem_wdata = dma_wr ? buf_q : cpu_data_out;
  assign cmd_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  always_comb begin
    state_d = state_q;
    src_d = src_q;
    dst_d = dst_q;
    cnt_d = cnt_q;
    buf_d = buf_q;
    if (state_q == IDLE) begin
      if (cmd_valid) begin
        src_d = cmd_src;
        dst_d = cmd_dst;
        cnt_d = cmd_len;
        state_d = (cmd_len == '0) ? DONE : READ;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (abort) begin
      // a bus access granted this cycle still happens; its pointer/count updates are dropped
      state_d = DONE;
    end else if (dma_rd) begin
      buf_d = mem_rdata;
      src_d = src_q + PTR_INC;
      state_d = WRITE;
    end else if (dma_wr) begin
      dst_d = dst_q + PTR_INC;
      cnt_d = cnt_q - LEN_W'(1);
      state_d = (cnt_q == LEN_W'(1)) ? DONE : READ;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      src_q <= '0;
      dst_q <= '0;
      cnt_q <= '0;
      buf_q <= '0;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      dst_q <= dst_d;
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  end
endmodule
